obstacle_scroller: RTL and testbench

//  Consumes the one-cycle tick from the clock divider and moves a single obstacle right-to-left across
//  the 1920x1080 active area, one step per tick.
//  On leaving the left edge the obstacle respawns at the right edge at a pseudo-random row, and the

---
 rtl/vga_game_pkg.sv | 17 +
 rtl/obstacle_scroller_if.sv | 26 ++
 rtl/lfsr16.sv | 31 +++
 rtl/obstacle_scroller.sv | 101 ++++++++++
 tb/tb_obstacle_scroller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA game blocks: screen geometry, coordinate width,
// game FSM encoding and the obstacle LFSR feedback taps.
package vga_game_pkg;

  localparam int          H_ACTIVE_PX = 1920;
  localparam int          V_ACTIVE_PX = 1080;
  localparam int          COORD_W     = 12;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/obstacle_scroller_if.sv
// Control inputs and position/score outputs between the game controller and the
// obstacle scroller; the master drives controls, the slave (scroller) drives outputs.
interface obstacle_scroller_if;
  import vga_game_pkg::*;

  logic               tick;
  logic               start;
  logic               pause;
  logic               collision;
  logic [COORD_W-1:0] obst_x;
  logic [COORD_W-1:0] obst_y;
  logic               respawn;
  logic               running;
  logic [15:0]        score;

  modport master (
    output tick, start, pause, collision,
    input  obst_x, obst_y, respawn, running, score
  );

  modport slave (
    input  tick, start, pause, collision,
    output obst_x, obst_y, respawn, running, score
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; shifts right every clock and folds the taps in
// when the bit shifted out is one.
module lfsr16
  import vga_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_148Mhz,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;
  logic [15:0] w_next;

  for (genvar gi = 0; gi < 15; gi++) begin : g_tap
    assign w_next[gi] = r_lfsr[gi+1] ^ (LFSR_TAPS[gi] & r_lfsr[0]);
  end
  assign w_next[15] = LFSR_TAPS[15] & r_lfsr[0];

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/obstacle_scroller.sv
// Moves one obstacle right-to-left by STEP pixels per divider tick; on leaving the
// left edge it respawns at the right edge on an LFSR-chosen row and bumps the score.
module obstacle_scroller
  import vga_game_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_PX,
  parameter int          STEP        = 8,
  parameter int          Y_MIN       = 256,
  parameter int          Y_SPAN_LOG2 = 9,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk_148Mhz,
  input  logic                reset,
  obstacle_scroller_if.slave  bus
);

  localparam logic [COORD_W-1:0] C_H_ACTIVE = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] C_STEP     = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] C_Y_MIN    = COORD_W'(Y_MIN);

  state_t             r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_respawn;
  logic               r_running;
  logic [15:0]        r_score;
  logic [15:0]        w_lfsr;
  logic               w_lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_148Mhz (clk_148Mhz),
    .reset      (reset),
    .q          (w_lfsr)
  );

  // Only the low Y_SPAN_LOG2 bits choose the row; the rest just keep the sequence long.
  assign w_lfsr_unused = &{1'b0, w_lfsr[15:Y_SPAN_LOG2]};

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x       <= C_H_ACTIVE;
      r_y       <= C_Y_MIN;
      r_respawn <= 1'b0;
      r_running <= 1'b0;
      r_score   <= 16'd0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_x       <= C_H_ACTIVE;
            r_score   <= 16'd0;
          end
        end
        RUN: begin
          // Collision outranks pause, which outranks a move on the same cycle.
          if (bus.collision) begin
            r_state   <= HALT;
            r_running <= 1'b0;
          end else if (bus.pause) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end else if (bus.tick) begin
            if (r_x >= C_STEP) begin
              r_x <= r_x - C_STEP;
            end else begin
              r_x       <= C_H_ACTIVE;
              r_y       <= C_Y_MIN + COORD_W'(w_lfsr[Y_SPAN_LOG2-1:0]);
              r_respawn <= 1'b1;
              if (r_score != 16'hFFFF) begin
                r_score <= r_score + 16'd1;
              end
            end
          end
        end
        PAUSED: begin
          if (!bus.pause) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.obst_x  = r_x;
  assign bus.obst_y  = r_y;
  assign bus.respawn = r_respawn;
  assign bus.running = r_running;
  assign bus.score   = r_score;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: a table of single-cycle vectors for the FSM
// transitions, then hand-written sequences for wraps, pause, collision, saturation and reset.
module tb_obstacle_scroller;
  import vga_game_pkg::*;

  typedef struct {
    logic        tick;
    logic        start;
    logic        pause;
    logic        coll;
    logic [11:0] x;
    logic        run;
    logic [15:0] score;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_at_edge;
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[11];

  always #5 clk = ~clk;

  obstacle_scroller_if bus();

  obstacle_scroller dut (
    .clk_148Mhz (clk),
    .reset      (rst),
    .bus        (bus)
  );

  // Reference Galois LFSR, advancing on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic vec_t mk(input logic t, s, p, c, input logic [11:0] x,
                              input logic r, input logic [15:0] sc, input string nm);
    vec_t v;
    v.tick = t; v.start = s; v.pause = p; v.coll = c;
    v.x = x; v.run = r; v.score = sc; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic p, input logic c);
    bus.tick = t; bus.start = s; bus.pause = p; bus.collision = c;
    lfsr_at_edge = m_lfsr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_wrap(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.respawn === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic chk_wrap_y(input string name);
    logic [11:0] exp_y;
    exp_y = 12'd256 + {3'd0, lfsr_at_edge[8:0]};
    chk(name, 32'(bus.obst_y), 32'(exp_y));
    chk({name, "_range"}, 32'(bus.obst_y >= 12'd256 && bus.obst_y <= 12'd767), 32'd1);
  endtask

  initial begin
    bit          seen;
    logic [11:0] saved_y;

    tbl[0]  = mk(0, 1, 0, 0, 12'd1920, 1, 16'd0, "tbl_start");
    tbl[1]  = mk(1, 0, 0, 0, 12'd1912, 1, 16'd0, "tbl_tick1");
    tbl[2]  = mk(1, 0, 0, 0, 12'd1904, 1, 16'd0, "tbl_tick2");
    tbl[3]  = mk(0, 0, 0, 0, 12'd1904, 1, 16'd0, "tbl_notick");
    tbl[4]  = mk(1, 0, 1, 0, 12'd1904, 0, 16'd0, "tbl_pause_over_tick");
    tbl[5]  = mk(1, 0, 1, 0, 12'd1904, 0, 16'd0, "tbl_paused_tick");
    tbl[6]  = mk(1, 0, 0, 0, 12'd1904, 1, 16'd0, "tbl_resume_tick_ignored");
    tbl[7]  = mk(1, 0, 0, 0, 12'd1896, 1, 16'd0, "tbl_tick3");
    tbl[8]  = mk(1, 0, 0, 1, 12'd1896, 0, 16'd0, "tbl_coll_over_tick");
    tbl[9]  = mk(1, 0, 0, 0, 12'd1896, 0, 16'd0, "tbl_halt_tick");
    tbl[10] = mk(0, 1, 0, 0, 12'd1920, 1, 16'd0, "tbl_restart");

    bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.collision = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_x",       32'(bus.obst_x),  32'd1920);
    chk("reset_y",       32'(bus.obst_y),  32'd256);
    chk("reset_running", 32'(bus.running), 32'd0);
    chk("reset_respawn", 32'(bus.respawn), 32'd0);
    chk("reset_score",   32'(bus.score),   32'd0);
    rst = 1'b0;

    cyc(1, 0, 0, 0);
    chk("idle_tick_x",       32'(bus.obst_x),  32'd1920);
    chk("idle_tick_running", 32'(bus.running), 32'd0);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].tick, tbl[i].start, tbl[i].pause, tbl[i].coll);
      chk({tbl[i].name, "_x"},       32'(bus.obst_x),  32'(tbl[i].x));
      chk({tbl[i].name, "_running"}, 32'(bus.running), 32'(tbl[i].run));
      chk({tbl[i].name, "_score"},   32'(bus.score),   32'(tbl[i].score));
      chk({tbl[i].name, "_respawn"}, 32'(bus.respawn), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0);
      chk($sformatf("ten_ticks_respawn_%0d", i), 32'(bus.respawn), 32'd0);
    end
    chk("ten_ticks_x",     32'(bus.obst_x), 32'd1840);
    chk("ten_ticks_score", 32'(bus.score),  32'd0);

    repeat (229) cyc(1, 0, 0, 0);
    chk("edge_x8", 32'(bus.obst_x), 32'd8);
    cyc(1, 0, 0, 0);
    chk("edge_x0", 32'(bus.obst_x), 32'd0);
    cyc(1, 0, 0, 0);
    chk("wrap1_x",       32'(bus.obst_x),  32'd1920);
    chk("wrap1_respawn", 32'(bus.respawn), 32'd1);
    chk("wrap1_score",   32'(bus.score),   32'd1);
    chk_wrap_y("wrap1_y");
    cyc(0, 0, 0, 0);
    chk("wrap1_pulse_end", 32'(bus.respawn), 32'd0);

    force dut.r_x = 12'd4;
    #1 release dut.r_x;
    cyc(1, 0, 0, 0);
    chk("wrap_x4_x",       32'(bus.obst_x),  32'd1920);
    chk("wrap_x4_respawn", 32'(bus.respawn), 32'd1);
    chk("wrap_x4_score",   32'(bus.score),   32'd2);
    chk_wrap_y("wrap_x4_y");

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0);
      chk($sformatf("pause_hold_x_%0d", i), 32'(bus.obst_x), 32'd1912);
    end
    chk("pause_running", 32'(bus.running), 32'd0);
    cyc(0, 0, 0, 0);
    chk("unpause_running", 32'(bus.running), 32'd1);
    cyc(1, 0, 0, 0);
    chk("unpause_tick_x", 32'(bus.obst_x), 32'd1904);

    repeat (138) cyc(1, 0, 0, 0);
    chk("pre_coll_x", 32'(bus.obst_x), 32'd800);
    saved_y = bus.obst_y;
    cyc(1, 0, 0, 1);
    chk("coll_x",       32'(bus.obst_x),  32'd800);
    chk("coll_running", 32'(bus.running), 32'd0);
    cyc(1, 0, 0, 0);
    chk("halt_frozen_x", 32'(bus.obst_x), 32'd800);
    cyc(0, 1, 0, 0);
    chk("halt_restart_x",       32'(bus.obst_x),  32'd1920);
    chk("halt_restart_score",   32'(bus.score),   32'd0);
    chk("halt_restart_y",       32'(bus.obst_y),  32'(saved_y));
    chk("halt_restart_running", 32'(bus.running), 32'd1);

    force dut.r_score = 16'hFFFE;
    #1 release dut.r_score;
    wait_wrap(seen);
    chk("sat_wrap1_seen",  32'(seen),      32'd1);
    chk("sat_wrap1_score", 32'(bus.score), 32'hFFFF);
    chk_wrap_y("sat_wrap1_y");
    wait_wrap(seen);
    chk("sat_wrap2_seen",  32'(seen),      32'd1);
    chk("sat_wrap2_score", 32'(bus.score), 32'hFFFF);

    cyc(1, 0, 0, 0);
    chk("pre_areset_x", 32'(bus.obst_x), 32'd1912);
    #2 rst = 1'b1;
    #1;
    chk("areset_x",       32'(bus.obst_x),  32'd1920);
    chk("areset_y",       32'(bus.obst_y),  32'd256);
    chk("areset_running", 32'(bus.running), 32'd0);
    chk("areset_respawn", 32'(bus.respawn), 32'd0);
    chk("areset_score",   32'(bus.score),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0);
    chk("post_areset_idle_x",       32'(bus.obst_x),  32'd1920);
    chk("post_areset_idle_running", 32'(bus.running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
